// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
// Load/store widths, FSM encoding and datapath width.
package mem_stage_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_t;

   // Natural alignment check; funct3[1:0] encodes the access size.
   function automatic logic is_aligned(input logic [2:0] f3,
                                       input logic [2:0] off);
      logic ok;
      ok = 1'b1;
      unique case (f3[1:0])
         2'b00: ok = 1'b1;
         2'b01: ok = (off[0] == 1'b0);
         2'b10: ok = (off[1:0] == 2'b00);
         2'b11: ok = (off == 3'b000);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension.
// Picks the addressed bytes out of an aligned word.
module mem_load_align #(
   parameter int XLEN = mem_stage_pkg::XLEN
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);
   import mem_stage_pkg::*;

   logic [XLEN-1:0] lane;

   assign lane = rdata >> {off, 3'b000};

   // Extend the selected lane; 011 and 111 pass the full word.
   always_comb begin
      data = lane;
      unique case (funct3)
         F3_B:  data = {{(XLEN-8){lane[7]}}, lane[7:0]};
         F3_H:  data = {{(XLEN-16){lane[15]}}, lane[15:0]};
         F3_W:  data = {{(XLEN-32){lane[31]}}, lane[31:0]};
         F3_BU: data = {{(XLEN-8){1'b0}}, lane[7:0]};
         F3_HU: data = {{(XLEN-16){1'b0}}, lane[15:0]};
         F3_WU: data = {{(XLEN-32){1'b0}}, lane[31:0]};
         default: data = lane;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: loads/stores over req/ready, branch redirect,
// and the registered write-back bundle.
module mem_stage #(
   parameter int XLEN   = mem_stage_pkg::XLEN,
   parameter int STRB_W = XLEN / 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [XLEN-1:0]   alu_res,
   input  logic              alu_wb_en,
   input  logic [4:0]        rd_i,
   input  logic              load_flag_i,
   input  logic              mem_en_i,
   input  logic [XLEN-1:0]   store_data_i,
   input  logic [2:0]        funct3_i,
   input  logic              branch_flag_i,
   input  logic [XLEN-1:0]   branch_offset_i,
   input  logic [XLEN-1:0]   PC_i,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [STRB_W-1:0] dmem_wstrb,
   input  logic              dmem_ready,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              misalign,
   output logic              stall
);
   import mem_stage_pkg::*;

   mem_state_t      state;
   logic [2:0]      funct3_q;
   logic [4:0]      rd_q;
   logic            load_q;
   logic [2:0]      off;
   logic            aligned;
   logic            start;
   logic [STRB_W-1:0] strb_base;
   logic [XLEN-1:0] ld_data;

   assign off     = alu_res[2:0];
   assign aligned = is_aligned(funct3_i, off);
   assign start   = mem_en_i & ~branch_flag_i & aligned;

   // Base byte-enable pattern for the store size, before lane shift.
   always_comb begin
      strb_base = '0;
      unique case (funct3_i[1:0])
         2'b00: strb_base = STRB_W'(8'h01);
         2'b01: strb_base = STRB_W'(8'h03);
         2'b10: strb_base = STRB_W'(8'h0F);
         2'b11: strb_base = STRB_W'(8'hFF);
         default: strb_base = '0;
      endcase
   end

   // Upstream freezes while a request is being launched or pending.
   always_comb begin
      stall = 1'b0;
      if (state == ST_IDLE)
         stall = start;
      else
         stall = ~dmem_ready;
   end

   mem_load_align #(.XLEN(XLEN)) u_align (
      .rdata  (dmem_rdata),
      .off    (dmem_addr[2:0]),
      .funct3 (funct3_q),
      .data   (ld_data)
   );

   // Two-state request FSM with registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state          <= ST_IDLE;
         funct3_q       <= '0;
         rd_q           <= '0;
         load_q         <= 1'b0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         dmem_wstrb     <= '0;
         wb_data        <= '0;
         wb_en          <= 1'b0;
         wb_rd          <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         misalign       <= 1'b0;
      end else begin
         redirect_valid <= 1'b0;
         misalign       <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (branch_flag_i || !mem_en_i) begin
                  wb_data <= alu_res;
                  wb_rd   <= rd_i;
                  wb_en   <= alu_wb_en & ~branch_flag_i & (rd_i != 5'd0);
                  if (branch_flag_i && alu_res[0]) begin
                     redirect_valid <= 1'b1;
                     redirect_pc    <= PC_i + branch_offset_i;
                  end
               end else if (aligned) begin
                  wb_en      <= 1'b0;
                  funct3_q   <= funct3_i;
                  rd_q       <= rd_i;
                  load_q     <= load_flag_i;
                  dmem_req   <= 1'b1;
                  dmem_we    <= ~load_flag_i;
                  dmem_addr  <= alu_res;
                  dmem_wdata <= store_data_i << {off, 3'b000};
                  dmem_wstrb <= load_flag_i ? '0 : (strb_base << off);
                  state      <= ST_BUSY;
               end else begin
                  wb_en    <= 1'b0;
                  misalign <= 1'b1;
               end
            end
            ST_BUSY: begin
               wb_en <= 1'b0;
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  state    <= ST_IDLE;
                  if (load_q) begin
                     wb_en   <= (rd_q != 5'd0);
                     wb_data <= ld_data;
                     wb_rd   <= rd_q;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Each step drives inputs, advances a clock and checks outputs.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [63:0] alu_res;
   logic        alu_wb_en;
   logic [4:0]  rd_i;
   logic        load_flag_i;
   logic        mem_en_i;
   logic [63:0] store_data_i;
   logic [2:0]  funct3_i;
   logic        branch_flag_i;
   logic [63:0] branch_offset_i;
   logic [63:0] PC_i;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [63:0] dmem_rdata;
   logic [63:0] wb_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        misalign;
   logic        stall;

   int passed = 0;
   int total  = 0;
   int stalls;

   always #5 CLK = ~CLK;

   mem_stage #(.XLEN(64), .STRB_W(8)) dut (
      .CLK             (CLK),
      .RST_N           (RST_N),
      .alu_res         (alu_res),
      .alu_wb_en       (alu_wb_en),
      .rd_i            (rd_i),
      .load_flag_i     (load_flag_i),
      .mem_en_i        (mem_en_i),
      .store_data_i    (store_data_i),
      .funct3_i        (funct3_i),
      .branch_flag_i   (branch_flag_i),
      .branch_offset_i (branch_offset_i),
      .PC_i            (PC_i),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_wstrb      (dmem_wstrb),
      .dmem_ready      (dmem_ready),
      .dmem_rdata      (dmem_rdata),
      .wb_data         (wb_data),
      .wb_en           (wb_en),
      .wb_rd           (wb_rd),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .misalign        (misalign),
      .stall           (stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      alu_res = '0; alu_wb_en = 0; rd_i = '0; load_flag_i = 0;
      mem_en_i = 0; store_data_i = '0; funct3_i = '0;
      branch_flag_i = 0; branch_offset_i = '0; PC_i = '0;
   endtask

   task automatic mem_op(input logic [63:0] a, input logic [2:0] f3,
                         input logic [4:0] rd, input logic ld,
                         input logic [63:0] sd);
      alu_res = a; funct3_i = f3; rd_i = rd; load_flag_i = ld;
      mem_en_i = 1; store_data_i = sd;
   endtask

   // Load with ready in the first BUSY cycle.
   task automatic do_load(input logic [63:0] a, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [63:0] rd_w);
      mem_op(a, f3, rd, 1'b1, '0);
      tick();
      idle_in();
      dmem_rdata = rd_w;
      dmem_ready = 1;
      tick();
      dmem_ready = 0;
   endtask

   initial begin
      RST_N = 0; dmem_ready = 0; dmem_rdata = '0;
      idle_in();
      tick(); tick();
      chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_req", {63'd0, dmem_req}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      RST_N = 1;
      tick();

      // ALU pass-through
      alu_res = 64'h1234; rd_i = 5'd5; alu_wb_en = 1;
      #1 chk("pt_stall", {63'd0, stall}, 64'd0);
      tick();
      chk("pt_wb_en", {63'd0, wb_en}, 64'd1);
      chk("pt_wb_rd", {59'd0, wb_rd}, 64'd5);
      chk("pt_wb_data", wb_data, 64'h1234);
      rd_i = 5'd0;
      tick();
      chk("pt_rd0_wb_en", {63'd0, wb_en}, 64'd0);
      idle_in();

      // LH at 0x1006, ready in the 4th BUSY cycle
      stalls = 0;
      dmem_rdata = 64'h8877665544332211;
      mem_op(64'h1006, 3'b001, 5'd7, 1'b1, '0);
      #1 if (stall) stalls++;
      tick();
      idle_in();
      chk("lh_req", {63'd0, dmem_req}, 64'd1);
      chk("lh_we", {63'd0, dmem_we}, 64'd0);
      chk("lh_addr", dmem_addr, 64'h1006);
      for (int k = 1; k <= 4; k++) begin
         dmem_ready = (k == 4);
         #1 if (stall) stalls++;
         tick();
         if (k < 4) begin
            chk("lh_busy_wb_en", {63'd0, wb_en}, 64'd0);
            chk("lh_busy_req", {63'd0, dmem_req}, 64'd1);
         end
      end
      dmem_ready = 0;
      chk("lh_stall_cycles", 64'(stalls), 64'd4);
      chk("lh_wb_en", {63'd0, wb_en}, 64'd1);
      chk("lh_wb_rd", {59'd0, wb_rd}, 64'd7);
      chk("lh_wb_data", wb_data, 64'hFFFFFFFFFFFF8877);
      chk("lh_req_done", {63'd0, dmem_req}, 64'd0);

      do_load(64'h1006, 3'b101, 5'd7, 64'h8877665544332211);
      chk("lhu_wb_data", wb_data, 64'h0000000000008877);
      do_load(64'h1001, 3'b000, 5'd2, 64'h8877665544332211);
      chk("lb_pos", wb_data, 64'h22);
      do_load(64'h1007, 3'b000, 5'd2, 64'h8877665544332211);
      chk("lb_neg", wb_data, 64'hFFFFFFFFFFFFFF88);
      do_load(64'h1007, 3'b100, 5'd2, 64'h8877665544332211);
      chk("lbu", wb_data, 64'h88);
      do_load(64'h1004, 3'b010, 5'd2, 64'h8877665544332211);
      chk("lw", wb_data, 64'hFFFFFFFF88776655);
      do_load(64'h1004, 3'b110, 5'd2, 64'h8877665544332211);
      chk("lwu", wb_data, 64'h0000000088776655);
      do_load(64'h1008, 3'b111, 5'd2, 64'h8877665544332211);
      chk("ld_f3_111", wb_data, 64'h8877665544332211);

      // SW at 0x2004, ready immediately
      mem_op(64'h2004, 3'b010, 5'd4, 1'b0, 64'hDEADBEEF);
      tick();
      idle_in();
      chk("sw_req", {63'd0, dmem_req}, 64'd1);
      chk("sw_we", {63'd0, dmem_we}, 64'd1);
      chk("sw_wstrb", {56'd0, dmem_wstrb}, 64'hF0);
      chk("sw_wdata", dmem_wdata, 64'hDEADBEEF00000000);
      dmem_ready = 1;
      #1 chk("sw_stall_ready", {63'd0, stall}, 64'd0);
      tick();
      dmem_ready = 0;
      chk("sw_wb_en", {63'd0, wb_en}, 64'd0);
      chk("sw_req_done", {63'd0, dmem_req}, 64'd0);

      // SB at 0x2003
      mem_op(64'h2003, 3'b000, 5'd4, 1'b0, 64'hAB);
      tick();
      idle_in();
      chk("sb_wstrb", {56'd0, dmem_wstrb}, 64'h08);
      chk("sb_wdata", dmem_wdata, 64'hAB000000);
      dmem_ready = 1;
      tick();
      dmem_ready = 0;

      // Branch taken then not taken
      branch_flag_i = 1; alu_res = 64'd1; PC_i = 64'h100;
      branch_offset_i = -64'sd8; alu_wb_en = 1; rd_i = 5'd3;
      tick();
      chk("br_redirect", {63'd0, redirect_valid}, 64'd1);
      chk("br_pc", redirect_pc, 64'hF8);
      chk("br_wb_en", {63'd0, wb_en}, 64'd0);
      idle_in();
      tick();
      chk("br_pulse_end", {63'd0, redirect_valid}, 64'd0);
      branch_flag_i = 1; alu_res = 64'd0; PC_i = 64'h100;
      branch_offset_i = -64'sd8;
      tick();
      chk("br_not_taken", {63'd0, redirect_valid}, 64'd0);
      idle_in();

      // Misaligned LW at 0x1002
      mem_op(64'h1002, 3'b010, 5'd6, 1'b1, '0);
      #1 chk("mis_stall", {63'd0, stall}, 64'd0);
      tick();
      chk("mis_flag", {63'd0, misalign}, 64'd1);
      chk("mis_req", {63'd0, dmem_req}, 64'd0);
      chk("mis_wb_en", {63'd0, wb_en}, 64'd0);
      idle_in();
      tick();
      chk("mis_pulse_end", {63'd0, misalign}, 64'd0);

      // Reset while BUSY with ready low
      mem_op(64'h3000, 3'b011, 5'd9, 1'b1, '0);
      tick();
      idle_in();
      chk("rb_req", {63'd0, dmem_req}, 64'd1);
      RST_N = 0;
      tick();
      chk("rb_req_drop", {63'd0, dmem_req}, 64'd0);
      chk("rb_addr", dmem_addr, 64'd0);
      chk("rb_wb_data", wb_data, 64'd0);
      RST_N = 1;
      #1 chk("rb_stall_idle", {63'd0, stall}, 64'd0);
      tick();
      do_load(64'h3008, 3'b011, 5'd0, 64'h0123456789ABCDEF);
      chk("ld_rd0_wb_en", {63'd0, wb_en}, 64'd0);
      chk("ld_rd0_data", wb_data, 64'h0123456789ABCDEF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU stage.
- Consumes the registered ALU result, destination register, load/mem/branch flags, funct3, PC and branch offset.
- Performs data-memory loads and stores over a req/ready handshake, sign/zero-extends load data and resolves taken branches into a PC redirect.
- Produces the registered write-back bundle for the register file and a stall to freeze upstream stages.

Parameters:
- XLEN, 64, datapath and address width.
- STRB_W, XLEN/8, byte-strobe width of the data-memory port.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- alu_res  in  XLEN  ALU result: memory address for loads/stores, bit0 = branch-taken for branches.
- alu_wb_en  in  1  ALU write-back enable.
- rd_i  in  5  destination register.
- load_flag_i  in  1  1 = load, 0 = store (meaningful only when mem_en_i=1).
- mem_en_i  in  1  memory access request.
- store_data_i  in  XLEN  rs2 value for stores.
- funct3_i  in  3  load/store width or branch type.
- branch_flag_i  in  1  instruction is a conditional branch.
- branch_offset_i  in  XLEN  sign-extended branch offset.
- PC_i  in  XLEN  instruction PC.
- dmem_req  out  1  memory request, held until accepted.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  byte address.
- dmem_wdata  out  XLEN  lane-aligned store data.
- dmem_wstrb  out  STRB_W  byte enables.
- dmem_ready  in  1  request accepted; for reads, dmem_rdata is valid in the same cycle.
- dmem_rdata  in  XLEN  aligned 64-bit read word.
- wb_data  out  XLEN  write-back value.
- wb_en  out  1  write-back enable.
- wb_rd  out  5  write-back register.
- redirect_valid  out  1  one-cycle pulse, taken branch.
- redirect_pc  out  XLEN  branch target.
- misalign  out  1  one-cycle pulse, misaligned access dropped.
- stall  out  1  upstream must hold its outputs.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - State goes to IDLE.
  - All outputs become 0.
  - Reset during BUSY drops dmem_req on the next edge without waiting for dmem_ready; the request is abandoned.
- FSM states: IDLE and BUSY.
- IDLE, no memory op (mem_en_i=0): 1-cycle latency.
  - wb_data<=alu_res.
  - wb_rd<=rd_i.
  - wb_en<=alu_wb_en & ~branch_flag_i & (rd_i!=0).
- IDLE, branch taken (branch_flag_i=1 and alu_res[0]=1):
  - redirect_valid<=1 for exactly one cycle.
  - redirect_pc<=PC_i+branch_offset_i, modulo 2^XLEN.
- IDLE, mem_en_i=1 and aligned:
  - Capture address, funct3, rd, load flag and aligned write data/strobes.
  - Set dmem_req<=1 and go to BUSY.
- Alignment rules:
  - Halfword: addr[0]=0.
  - Word: addr[1:0]=0.
  - Dword: addr[2:0]=0.
  - Misaligned: misalign<=1 for one cycle, no request, wb_en<=0, stay in IDLE.
- BUSY:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable.
  - wb_en=0 every cycle until completion.
  - On dmem_ready=1: dmem_req<=0, return to IDLE.
  - Load completion: wb_en<=(rd!=0), wb_data<=extended lane.
  - Store completion: wb_en<=0.
- stall is combinational: (IDLE & mem_en_i & aligned) | (BUSY & ~dmem_ready).
- Minimum load latency is 2 cycles: capture edge, then ready sampled in BUSY, then write-back edge.
- Store encoding:
  - SB=000, SH=001, SW=010, SD=011.
  - dmem_wdata = store_data_i << (addr[2:0]*8).
  - dmem_wstrb = (1/3/F/FF) << addr[2:0].
- Load encoding:
  - LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - Lane = dmem_rdata >> (addr[2:0]*8).
  - 000/001/010 sign-extend; 100/101/110 zero-extend; 011 passes 64 bits.
  - funct3=111: treated as LD.
- Branch and memory are mutually exclusive; branch has priority.
- Inputs are ignored while BUSY, because upstream is stalled.

Decomposition:
- Shared package holds:
  - Load/store funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - State encoding (ST_IDLE, ST_BUSY).
  - XLEN.
- One sub-module, mem_load_align: combinational lane select plus sign/zero extension from (rdata, addr[2:0], funct3).

Test Plan:
- ALU pass-through: alu_res=0x1234, rd_i=5, alu_wb_en=1 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234, stall=0 throughout.
- LH at 0x1006, rdata=0x8877665544332211, ready 3 cycles after req -> stall high 4 cycles, wb_data=0xFFFFFFFFFFFF8877; with LHU -> 0x0000000000008877.
- SW at 0x2004, store_data=0xDEADBEEF, ready=1 immediately -> dmem_we=1, wstrb=0xF0, wdata=0xDEADBEEF00000000, wb_en=0.
- Branch: branch_flag_i=1, alu_res=1, PC_i=0x100, offset=-8 -> redirect_valid pulse 1 cycle, redirect_pc=0xF8, wb_en=0; with alu_res=0 -> no pulse.
- LW at 0x1002 -> misalign=1 for one cycle, dmem_req stays 0, wb_en=0.
- RST_N=0 in BUSY with ready held low -> next edge dmem_req=0, state IDLE, all outputs 0; a later LD to rd=0 completes with wb_en=0.
